// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: trap vectors, next-PC selects, opcodes.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [31:0] VEC_RESET = 32'h8000_0000;
    localparam logic [31:0] VEC_IRQ   = 32'h8000_0004;
    localparam logic [31:0] VEC_EXC   = 32'h8000_0008;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'd0,
        PCSEL_BR  = 2'd1,
        PCSEL_J   = 2'd2,
        PCSEL_JR  = 2'd3
    } pc_sel_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // True for every opcode the core implements; anything else traps when checking is enabled.
    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI, OP_LW, OP_SW:
                is_legal_op = 1'b1;
            default:
                is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Computes the sequential, branch and jump candidates for the next PC from pc and instr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module pc_target_calc (
    input  logic [31:0] pc,
    input  logic [25:0] instr_low,
    output logic [31:0] seq_target,
    output logic [31:0] br_target,
    output logic [31:0] j_target
);

    logic [30:0] br_off;

    // Offsets and adds stay within bits [30:0] so the supervisor bit never changes on these paths.
    always_comb begin
        br_off     = {{13{instr_low[15]}}, instr_low[15:0], 2'b00};
        seq_target = {pc[31], pc[30:0] + 31'd4};
        br_target  = {pc[31], seq_target[30:0] + br_off};
        j_target   = {pc[31:28], instr_low, 2'b00};
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, next-PC select and trap entry (interrupt; illegal opcode when PC_FETCH_ILLOP_EN is defined).
// Latency: new pc one clock after selection; epc_we/kill asserted in the decision cycle.
// Backpressure: stall holds pc and irq_pend and suppresses all traps for that cycle.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = VEC_RESET,
    parameter logic [31:0] IRQ_VEC   = VEC_IRQ,
    parameter logic [31:0] EXC_VEC   = VEC_EXC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    input  logic        irq,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        epc_we,
    output logic        kill,
    output logic        supervisor
);

    logic [31:0] pc_q;
    logic        irq_pend;
    logic [31:0] seq_target;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] normal_nxt;
    logic [31:0] pc_nxt;
    logic        exc;
    logic        irq_take;

    pc_target_calc u_target (
        .pc         (pc_q),
        .instr_low  (instr[25:0]),
        .seq_target (seq_target),
        .br_target  (br_target),
        .j_target   (j_target)
    );

`ifdef PC_FETCH_ILLOP_EN
    logic unused_bits;
    assign unused_bits = ^jr_target[1:0];
    assign exc         = !stall && !is_legal_op(instr[31:26]);
`else
    logic unused_bits;
    assign unused_bits = ^{instr[31:26], jr_target[1:0]};
    assign exc         = 1'b0;
`endif

    // Interrupts are only taken from user mode, on an unstalled cycle, and yield to exceptions.
    assign irq_take = irq_pend && !pc_q[31] && !stall && !exc;

    // Normal next-PC mux; register jumps drop the low bits so pc stays word aligned.
    always_comb begin
        normal_nxt = seq_target;
        case (pc_sel_e'(pc_sel))
            PCSEL_SEQ: normal_nxt = seq_target;
            PCSEL_BR:  normal_nxt = branch_taken ? br_target : seq_target;
            PCSEL_J:   normal_nxt = j_target;
            PCSEL_JR:  normal_nxt = {jr_target[31:2], 2'b00};
            default:   normal_nxt = seq_target;
        endcase
    end

    // Trap priority: stall hold, then exception, then interrupt, then normal flow.
    always_comb begin
        pc_nxt = normal_nxt;
        if (stall) begin
            pc_nxt = pc_q;
        end else if (exc) begin
            pc_nxt = EXC_VEC;
        end else if (irq_take) begin
            pc_nxt = IRQ_VEC;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_nxt;
        end
    end

    // Pending interrupt latch; taking the interrupt beats a coincident request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_pend <= 1'b0;
        end else if (irq_take) begin
            irq_pend <= 1'b0;
        end else if (irq) begin
            irq_pend <= 1'b1;
        end
    end

    assign pc         = pc_q;
    assign pc_plus4   = seq_target;
    assign epc        = pc_q;
    assign epc_we     = exc || irq_take;
    assign kill       = exc || irq_take;
    assign supervisor = pc_q[31];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit.
// Latency: each step drives one cycle of inputs and queues that cycle's expected outputs.
// Backpressure: the monitor pops one expectation per falling edge while any are queued.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        stall;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] jr_target;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        epc_we;
    logic        kill;
    logic        supervisor;

    typedef struct {
        logic [31:0] pc;
        logic        trap;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BEQ  = 32'h1000_FFF8;
    localparam logic [31:0] JAL  = 32'h0C00_002A;
    localparam logic [31:0] ILL  = 32'hFC00_0000;

    pc_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .irq          (irq),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .epc          (epc),
        .epc_we       (epc_we),
        .kill         (kill),
        .supervisor   (supervisor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %08h expected %08h", nm, field, act, exp);
        end
    endtask

    // Monitor: compares every presented cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [31:0] p4;
            e  = sb.pop_front();
            p4 = {e.pc[31], e.pc[30:0] + 31'd4};
            chk(e.name, "pc", pc, e.pc);
            chk(e.name, "pc_plus4", pc_plus4, p4);
            chk(e.name, "supervisor", {31'd0, supervisor}, {31'd0, e.pc[31]});
            chk(e.name, "epc_we", {31'd0, epc_we}, {31'd0, e.trap});
            chk(e.name, "kill", {31'd0, kill}, {31'd0, e.trap});
            if (e.trap) chk(e.name, "epc", epc, e.pc);
        end
    end

    // Drive one cycle of inputs after the rising edge and queue the expected outputs for it.
    task automatic step(input logic rst_i, input logic stl_i, input logic [1:0] sel_i,
                        input logic br_i, input logic irq_i, input logic [31:0] ins_i,
                        input logic [31:0] jr_i, input logic [31:0] exp_pc,
                        input logic exp_trap, input string nm);
        exp_t e;
        reset        = rst_i;
        stall        = stl_i;
        pc_sel       = sel_i;
        branch_taken = br_i;
        irq          = irq_i;
        instr        = ins_i;
        jr_target    = jr_i;
        e.pc   = exp_pc;
        e.trap = exp_trap;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pc_sel = 2'd0; branch_taken = 1'b0;
        irq = 1'b0; instr = NOP; jr_target = 32'h0;
        @(posedge clk);
        #1;
        //   rst  stl sel   br   irq  instr jr             exp_pc         trap
        step(1'b1,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h8000_0000, 1'b0, "reset_state");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h8000_0000, 1'b0, "release");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h8000_0004, 1'b0, "seq0");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h0000_0120, 32'h8000_0008, 1'b0, "jr_120");
        step(1'b0,1'b1,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h0000_0120, 1'b0, "at_120");
        step(1'b1,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h8000_0000, 1'b0, "midrun_reset");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h8000_0000, 1'b0, "rel2");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h8000_0004, 1'b0, "seq_04");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h0000_00FC, 32'h8000_0008, 1'b0, "seq_08");
        // Branches
        step(1'b0,1'b0,2'd1,1'b1,1'b0,BEQ, 32'h0,         32'h0000_00FC, 1'b0, "br_at_fc");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h0000_00FC, 32'h0000_00E0, 1'b0, "br_taken");
        step(1'b0,1'b0,2'd1,1'b0,1'b0,BEQ, 32'h0,         32'h0000_00FC, 1'b0, "br_at_fc2");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h8000_00A7, 32'h0000_0100, 1'b0, "br_not_taken");
        // Jump and register jump (unaligned target is aligned down)
        step(1'b0,1'b0,2'd2,1'b0,1'b0,JAL, 32'h0,         32'h8000_00A4, 1'b0, "jr_unaligned");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h0000_00BC, 32'h8000_00A8, 1'b0, "jal_target");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'hFFFF_FFFC, 32'h0000_00BC, 1'b0, "jr_user");
        // Sequential wrap stays in mode
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'hFFFF_FFFC, 1'b0, "at_fffffffc");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h7FFF_FFFC, 32'h8000_0000, 1'b0, "wrap_kernel");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h7FFF_FFFC, 1'b0, "at_7ffffffc");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h8000_0010, 32'h0000_0000, 1'b0, "wrap_user");
        // Interrupt in kernel is deferred until user mode
        step(1'b0,1'b0,2'd0,1'b0,1'b1,NOP, 32'h0,         32'h8000_0010, 1'b0, "irq_kernel");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h8000_0014, 1'b0, "kernel_no_trap");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h0000_0040, 32'h8000_0018, 1'b0, "kernel_exit");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h0000_0040, 1'b1, "irq_taken_40");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h0000_0050, 32'h8000_0004, 1'b0, "irq_vector");
        // Interrupt during stall waits for the first unstalled cycle
        step(1'b0,1'b1,2'd0,1'b0,1'b1,NOP, 32'h0,         32'h0000_0050, 1'b0, "pend_cleared");
        step(1'b0,1'b1,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h0000_0050, 1'b0, "stall_no_trap");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h0000_0050, 1'b1, "unstall_trap");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h0000_0060, 32'h8000_0004, 1'b0, "irq_vector2");
        // Clear wins over a coincident request
        step(1'b0,1'b0,2'd0,1'b0,1'b1,NOP, 32'h0,         32'h0000_0060, 1'b0, "set_pend");
        step(1'b0,1'b0,2'd0,1'b0,1'b1,NOP, 32'h0,         32'h0000_0064, 1'b1, "trap_with_irq");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h0000_0070, 32'h8000_0004, 1'b0, "irq_vector3");
        step(1'b0,1'b0,2'd3,1'b0,1'b1,NOP, 32'h0000_0060, 32'h0000_0070, 1'b0, "clear_won");
`ifdef PC_FETCH_ILLOP_EN
        step(1'b0,1'b0,2'd0,1'b0,1'b0,ILL, 32'h0,         32'h0000_0060, 1'b1, "illop_trap");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h0000_0080, 32'h8000_0008, 1'b0, "exc_vector");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h0000_0080, 1'b1, "pend_kept");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h8000_0004, 1'b0, "irq_vector4");
`else
        step(1'b0,1'b0,2'd0,1'b0,1'b0,ILL, 32'h0,         32'h0000_0060, 1'b1, "illop_ignored");
        step(1'b0,1'b0,2'd3,1'b0,1'b0,NOP, 32'h0000_0080, 32'h8000_0004, 1'b0, "irq_vector4");
        step(1'b0,1'b0,2'd0,1'b0,1'b0,NOP, 32'h0,         32'h0000_0080, 1'b0, "no_trap_80");
`endif
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and next-PC stage of the single-cycle MIPS core; sits directly upstream of the instruction ROM.
- Drives the ROM word address and receives the fetched instruction word back.
- Selects the next PC from sequential, branch, jump, or register sources, and from the reset, interrupt and exception vectors.
- PC[31] is the supervisor bit: set inside the kernel, cleared by the handler's jr; interrupts are taken only in user mode.

Parameters:
- RESET_VEC, 32'h8000_0000, PC value loaded on reset.
- IRQ_VEC, 32'h8000_0004, interrupt entry address.
- EXC_VEC, 32'h8000_0008, exception entry address.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- instr  in  32  instruction word from ROM for the current PC
- stall  in  1  hold PC this cycle
- pc_sel  in  2  0=PC+4, 1=branch, 2=jump (J/JAL), 3=register (JR/JALR)
- branch_taken  in  1  branch condition true (valid when pc_sel=1)
- jr_target  in  32  rs value for register jumps
- irq  in  1  level interrupt request (timer)
- pc  out  32  current PC; ROM address
- pc_plus4  out  32  {pc[31], pc[30:0]+4}; link value for JAL
- epc  out  32  address saved on trap entry
- epc_we  out  1  write epc into $26 this cycle
- kill  out  1  squash current instruction (no reg/mem write)
- supervisor  out  1  equals pc[31]

Behaviour:
- Reset (async): pc=RESET_VEC; irq_pend=0.
  - All combinational outputs follow from pc: epc_we=0, kill=0, supervisor=1.
- Sequential target: pc_plus4. Bit 31 is preserved; the 31-bit add wraps within the same mode.
- Branch target: pc_plus4 + (sign-extended instr[15:0] << 2), with bit 31 forced to pc[31]. Used only when branch_taken=1; otherwise pc_plus4.
- Jump target: {pc[31:28], instr[25:0], 2'b00}.
- Register target: jr_target taken verbatim; its bit 31 sets the new mode (this is the kernel-exit path).
- irq_pend register:
  - set on any cycle with irq=1;
  - cleared on the cycle the interrupt is taken;
  - if set and clear coincide, clear wins; a still-high irq re-sets it next cycle.
- Trap decision, combinational, in priority order:
  1. Exception (see optional feature): vector to EXC_VEC regardless of mode.
  2. Interrupt: irq_pend=1 and pc[31]=0 and stall=0. Then next pc=IRQ_VEC, epc=pc (the interrupted instruction is re-executed on return), epc_we=1, kill=1.
  3. Otherwise: normal next-PC selection.
- Stall: pc and irq_pend hold; irq may still set irq_pend; no trap is taken; epc_we=0; kill=0.
- Mid-operation reset returns to RESET_VEC in the same instant; pending interrupts are discarded.
- Latency:
  - new pc is visible one clock after selection;
  - trap side effects (epc_we, kill) are asserted in the same cycle as the decision.
- pc[1:0] is always 0. Unaligned jr_target has bits [1:0] forced to 0.

Optional Feature:
- Macro: PC_FETCH_ILLOP_EN.
- Defined: an instr opcode outside {00,01,02,03,04,05,06,07,08,09,0A,0B,0C,0F,23,2B} (hex), seen while stall=0, is an exception:
  - next pc=EXC_VEC, epc=pc, epc_we=1, kill=1;
  - takes priority over interrupt;
  - irq_pend is not cleared.
- Undefined: no opcode check; exceptions never occur; instr is used only for target computation.

Decomposition:
- Shared package cpu_pkg:
  - vector constants (RESET_VEC, IRQ_VEC, EXC_VEC);
  - pc_sel encodings (PCSEL_SEQ/BR/J/JR);
  - opcode constants used by the legal-opcode check.
- One natural sub-module: pc_target_calc, purely combinational, computing the branch, jump and sequential targets. The top level holds the registers and the trap priority logic.

Test Plan:
- Reset asserted mid-run at pc=0x0000_0120 -> pc=0x8000_0000 immediately; after release with pc_sel=0, the next pc values are 0x8000_0004, then 0x8000_0008.
- pc=0x0000_00FC, pc_sel=1, instr[15:0]=16'hFFF8, branch_taken=1 -> next pc=0x0000_00E0. With branch_taken=0 -> 0x0000_0100.
- pc=0x8000_00A4, pc_sel=2, instr=32'h0C00_002A -> next pc=0x8000_00A8 and pc_plus4=0x8000_00A8. Then pc_sel=3 with jr_target=0x0000_00BC -> pc=0x0000_00BC and supervisor=0.
- irq pulsed one cycle while pc=0x8000_0010 -> no trap while in kernel. After jr to 0x0000_0040 -> epc=0x0000_0040, epc_we=1, kill=1, next pc=0x8000_0004, irq_pend cleared.
- irq high during stall=1 at pc=0x0000_0050 -> pc holds and no trap. At the first cycle with stall=0 -> vector taken with epc=0x0000_0050.
- With PC_FETCH_ILLOP_EN: instr=32'hFC00_0000 at pc=0x0000_0060 while irq_pend=1 -> next pc=0x8000_0008, epc=0x0000_0060, irq_pend still 1.
